// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller around one shared full adder.
// Operands are consumed LSB first, one bit per clock.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             c;
    logic             cmsb;
    logic             fs;
    logic             fc;

    assign fs = op_a[0] ^ op_b[0] ^ c;
    assign fc = (op_a[0] & op_b[0]) | (op_a[0] & c) | (op_b[0] & c);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            cnt   <= '0;
            c     <= 1'b0;
            cmsb  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            co    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1; the +1 enters as carry-in.
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        c     <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    op_a <= op_a >> 1;
                    op_b <= op_b >> 1;
                    res  <= {fs, res[WIDTH-1:1]};
                    c    <= fc;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 2)) begin
                        cmsb <= fc;
                    end
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum   <= {fs, res[WIDTH-1:1]};
                        co    <= fc;
                        ovf   <= fc ^ cmsb;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
